pc_ctrl: RTL and testbench

- Next-PC sequencer for the 25-bit PC register in the fetch stage. Drives its npc, npc_enn and n_stall inputs.
- Arbitrates redirect requests from three sources: trap/loader vector, EX-stage branch resolution and ID-stage jump.
- Holds a redirect pending while the pipeline is stalled.
- Gates fetch until the boot loader signals ready.
- Generates the matching pipeline flush strobes.

---
 rtl/pc_ctrl_pkg.sv | 20 ++
 rtl/redir_prio_sel.sv | 48 ++++
 rtl/pc_ctrl.sv | 138 +++++++++++++
 tb/tb_pc_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the next-PC sequencer: FSM states and redirect source encoding.
// Lower redir_src_t value means higher arbitration priority.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_TRAP = 2'd0,
    SRC_EX   = 2'd1,
    SRC_ID   = 2'd2,
    SRC_NONE = 2'd3
  } redir_src_t;

  localparam int unsigned PC_W_DEF = 25;

endpackage

// File: rtl/redir_prio_sel.sv
// Combinational priority select over trap, ex, id requests and the held pending entry.
// A pending entry wins only if strictly higher priority than the best new request.
module redir_prio_sel
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic              trap_valid,
  input  logic [PC_W-1:0]   trap_target,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   id_target,
  input  redir_src_t        pend_src,
  input  logic [PC_W-1:0]   pend_tgt,
  output redir_src_t        win_src,
  output logic [PC_W-1:0]   win_tgt
);

  redir_src_t      new_src;
  logic [PC_W-1:0] new_tgt;

  always_comb begin
    new_src = SRC_NONE;
    new_tgt = '0;
    if (trap_valid) begin
      new_src = SRC_TRAP;
      new_tgt = trap_target;
    end else if (ex_valid) begin
      new_src = SRC_EX;
      new_tgt = ex_target;
    end else if (id_valid) begin
      new_src = SRC_ID;
      new_tgt = id_target;
    end
  end

  always_comb begin
    win_src = new_src;
    win_tgt = new_tgt;
    // SRC_NONE is the largest code, so a valid pending entry beats "no request".
    if (pend_src != SRC_NONE && pend_src < new_src) begin
      win_src = pend_src;
      win_tgt = pend_tgt;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Next-PC sequencer: arbitrates redirects, holds them across stalls, gates fetch until boot.
// Optional performance counters are enabled by defining PC_CTRL_PERF_EN.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter bit          BOOT_WAIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            boot_go,
  input  logic            stall_req,
  input  logic            trap_valid,
  input  logic [PC_W-1:0] trap_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_target,
  input  logic            id_valid,
  input  logic [PC_W-1:0] id_target,
  output logic [PC_W-1:0] npc,
  output logic            npc_enn,
  output logic            n_stall,
  output logic            flush_if,
  output logic            flush_id,
  output logic            flush_ex,
`ifdef PC_CTRL_PERF_EN
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_stall_cyc,
`endif
  output logic            pend_valid
);

  localparam state_t RstState = BOOT_WAIT ? BOOT : RUN;

  state_t          state_q;
  logic            pend_valid_q;
  redir_src_t      pend_src_q;
  logic [PC_W-1:0] pend_tgt_q;

  redir_src_t      pend_src_eff;
  redir_src_t      win_src;
  logic [PC_W-1:0] win_tgt;
  logic            active;
  logic            has_win;

  assign pend_src_eff = pend_valid_q ? pend_src_q : SRC_NONE;

  redir_prio_sel #(
    .PC_W (PC_W)
  ) u_sel (
    .trap_valid  (trap_valid),
    .trap_target (trap_target),
    .ex_valid    (ex_valid),
    .ex_target   (ex_target),
    .id_valid    (id_valid),
    .id_target   (id_target),
    .pend_src    (pend_src_eff),
    .pend_tgt    (pend_tgt_q),
    .win_src     (win_src),
    .win_tgt     (win_tgt)
  );

  assign active  = (state_q != BOOT);
  assign has_win = active && (win_src != SRC_NONE);

  always_comb begin
    npc      = '0;
    npc_enn  = 1'b0;
    n_stall  = 1'b0;
    flush_if = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (active && !stall_req) begin
      n_stall = 1'b1;
      if (has_win) begin
        // The PC register presents pc_reg+1, so load target-1 (wraps at zero).
        npc      = win_tgt - {{(PC_W-1){1'b0}}, 1'b1};
        npc_enn  = 1'b1;
        flush_if = 1'b1;
        flush_id = (win_src == SRC_TRAP) || (win_src == SRC_EX);
        flush_ex = (win_src == SRC_TRAP);
      end
    end
  end

  assign pend_valid = pend_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RstState;
      pend_valid_q <= 1'b0;
      pend_src_q   <= SRC_NONE;
      pend_tgt_q   <= '0;
    end else begin
      unique case (state_q)
        BOOT: begin
          if (boot_go) state_q <= RUN;
        end
        RUN, HOLD: begin
          if (!stall_req) begin
            state_q      <= RUN;
            pend_valid_q <= 1'b0;
            pend_src_q   <= SRC_NONE;
            pend_tgt_q   <= '0;
          end else if (has_win) begin
            state_q      <= HOLD;
            pend_valid_q <= 1'b1;
            pend_src_q   <= win_src;
            pend_tgt_q   <= win_tgt;
          end
        end
        default: state_q <= RstState;
      endcase
    end
  end

`ifdef PC_CTRL_PERF_EN
  logic [31:0] perf_redirects_q;
  logic [31:0] perf_stall_cyc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_redirects_q <= '0;
      perf_stall_cyc_q <= '0;
    end else begin
      if (npc_enn && perf_redirects_q != 32'hFFFF_FFFF) begin
        perf_redirects_q <= perf_redirects_q + 32'd1;
      end
      if (active && stall_req && perf_stall_cyc_q != 32'hFFFF_FFFF) begin
        perf_stall_cyc_q <= perf_stall_cyc_q + 32'd1;
      end
    end
  end

  assign perf_redirects = perf_redirects_q;
  assign perf_stall_cyc = perf_stall_cyc_q;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl with a behavioural model of the downstream PC register.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  localparam int unsigned PC_W = 25;

  logic            clk = 1'b0;
  logic            rst;
  logic            boot_go, stall_req;
  logic            trap_valid, ex_valid, id_valid;
  logic [PC_W-1:0] trap_target, ex_target, id_target;
  logic [PC_W-1:0] npc;
  logic            npc_enn, n_stall, flush_if, flush_id, flush_ex, pend_valid;
`ifdef PC_CTRL_PERF_EN
  logic [31:0]     perf_redirects, perf_stall_cyc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_ctrl #(
    .PC_W      (PC_W),
    .BOOT_WAIT (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .boot_go     (boot_go),
    .stall_req   (stall_req),
    .trap_valid  (trap_valid),
    .trap_target (trap_target),
    .ex_valid    (ex_valid),
    .ex_target   (ex_target),
    .id_valid    (id_valid),
    .id_target   (id_target),
    .npc         (npc),
    .npc_enn     (npc_enn),
    .n_stall     (n_stall),
    .flush_if    (flush_if),
    .flush_id    (flush_id),
    .flush_ex    (flush_ex),
`ifdef PC_CTRL_PERF_EN
    .perf_redirects (perf_redirects),
    .perf_stall_cyc (perf_stall_cyc),
`endif
    .pend_valid  (pend_valid)
  );

  // Model of the PC register being driven: it outputs pc_reg+1.
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_out;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_reg <= '0;
    else if (n_stall) pc_reg <= npc_enn ? npc : pc_reg + 1'b1;
  end
  assign pc_out = pc_reg + 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    trap_valid = 1'b0; ex_valid = 1'b0; id_valid = 1'b0;
    trap_target = '0; ex_target = '0; id_target = '0;
  endtask

  initial begin
    rst = 1'b0; boot_go = 1'b0; stall_req = 1'b0;
    clr_in();
    #2;
    check("rst_n_stall", 32'(n_stall), 32'd0);
    check("rst_pend", 32'(pend_valid), 32'd0);
    check("rst_npc_enn", 32'(npc_enn), 32'd0);
    step();
    rst = 1'b1;

    // BOOT: redirects ignored while waiting for boot_go.
    trap_valid = 1'b1; trap_target = 25'h40;
    for (int i = 0; i < 5; i++) begin
      step();
      check("boot_n_stall", 32'(n_stall), 32'd0);
    end
    check("boot_ignore_enn", 32'(npc_enn), 32'd0);
    check("boot_ignore_flush", 32'(flush_if), 32'd0);
    clr_in();
    boot_go = 1'b1; #1;
    check("boot_go_same", 32'(n_stall), 32'd0);
    step();
    boot_go = 1'b0; #1;
    check("run_n_stall", 32'(n_stall), 32'd1);
    check("run_enn", 32'(npc_enn), 32'd0);
    check("run_npc", 32'(npc), 32'd0);

    // ID jump.
    id_valid = 1'b1; id_target = 25'h100; #1;
    check("id_npc", 32'(npc), 32'h0FF);
    check("id_enn", 32'(npc_enn), 32'd1);
    check("id_fif", 32'(flush_if), 32'd1);
    check("id_fid", 32'(flush_id), 32'd0);
    step();
    check("id_pc", 32'(pc_out), 32'h100);

    // EX beats ID; trap beats both.
    ex_valid = 1'b1; ex_target = 25'h200; #1;
    check("ex_npc", 32'(npc), 32'h1FF);
    check("ex_fid", 32'(flush_id), 32'd1);
    check("ex_fex", 32'(flush_ex), 32'd0);
    trap_valid = 1'b1; trap_target = 25'h40; #1;
    check("trap_npc", 32'(npc), 32'h03F);
    check("trap_fex", 32'(flush_ex), 32'd1);
    check("trap_fid", 32'(flush_id), 32'd1);
    step();
    check("trap_pc", 32'(pc_out), 32'h40);
    clr_in();

    // Three-cycle stall: ID then EX requests, EX must survive and apply at release.
    stall_req = 1'b1; id_valid = 1'b1; id_target = 25'h80; #1;
    check("st1_n_stall", 32'(n_stall), 32'd0);
    check("st1_enn", 32'(npc_enn), 32'd0);
    check("st1_fif", 32'(flush_if), 32'd0);
    step();
    clr_in(); ex_valid = 1'b1; ex_target = 25'h90; #1;
    check("st2_pend", 32'(pend_valid), 32'd1);
    check("st2_n_stall", 32'(n_stall), 32'd0);
    step();
    clr_in(); #1;
    check("st3_pend", 32'(pend_valid), 32'd1);
    check("st3_enn", 32'(npc_enn), 32'd0);
    step();
    stall_req = 1'b0; #1;
    check("rel_npc", 32'(npc), 32'h08F);
    check("rel_enn", 32'(npc_enn), 32'd1);
    check("rel_fid", 32'(flush_id), 32'd1);
    check("rel_fex", 32'(flush_ex), 32'd0);
    step();
    check("rel_pend", 32'(pend_valid), 32'd0);
    check("rel_pc", 32'(pc_out), 32'h90);

    // Pending trap strictly outranks a new EX request.
    stall_req = 1'b1; trap_valid = 1'b1; trap_target = 25'h300;
    step();
    clr_in(); stall_req = 1'b0; ex_valid = 1'b1; ex_target = 25'h400; #1;
    check("ptrap_npc", 32'(npc), 32'h2FF);
    check("ptrap_fex", 32'(flush_ex), 32'd1);
    step();

    // Equal priority: new EX beats pending EX.
    stall_req = 1'b1; ex_target = 25'h500;
    step();
    stall_req = 1'b0; ex_target = 25'h600; #1;
    check("eq_npc", 32'(npc), 32'h5FF);
    step();
    clr_in();

    // Target zero wraps.
    trap_valid = 1'b1; trap_target = '0; #1;
    check("wrap_npc", 32'(npc), 32'h1FF_FFFF);
    check("wrap_fex", 32'(flush_ex), 32'd1);
    step();
    clr_in();

    // Reset during HOLD drops the pending redirect.
    stall_req = 1'b1; id_valid = 1'b1; id_target = 25'h80;
    step();
    clr_in(); #1;
    check("hold_pend", 32'(pend_valid), 32'd1);
    rst = 1'b0; #1;
    check("mrst_pend", 32'(pend_valid), 32'd0);
    check("mrst_n_stall", 32'(n_stall), 32'd0);
    step();
    rst = 1'b1; stall_req = 1'b0; boot_go = 1'b1;
    step();
    boot_go = 1'b0; #1;
    check("post_enn", 32'(npc_enn), 32'd0);
    check("post_n_stall", 32'(n_stall), 32'd1);
    check("post_pend", 32'(pend_valid), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
